// File: rtl/pleasure_integrator.sv
// Integrates pleasure_inc/pleasure_dec requests into a saturating level, updated on a prescaled tick,
// and classifies it into a LOW/NEUTRAL/HIGH mood with hysteresis. Define DECAY_EN to enable idle decay toward MID.
module pleasure_integrator #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 4,
  parameter int TICK_DIV    = 4,
  parameter int HI_ON       = 192,
  parameter int HI_OFF      = 160,
  parameter int LO_ON       = 64,
  parameter int LO_OFF      = 96,
  parameter int DECAY_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pleasure_inc,
  input  logic             pleasure_dec,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       mood,
  output logic             changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] MID    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   MAX_W  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] HI_ON_L  = WIDTH'(HI_ON);
  localparam logic [WIDTH-1:0] HI_OFF_L = WIDTH'(HI_OFF);
  localparam logic [WIDTH-1:0] LO_ON_L  = WIDTH'(LO_ON);
  localparam logic [WIDTH-1:0] LO_OFF_L = WIDTH'(LO_OFF);

  typedef enum logic [1:0] {
    MOOD_LOW     = 2'b00,
    MOOD_NEUTRAL = 2'b01,
    MOOD_HIGH    = 2'b10
  } mood_t;

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sat_up;
  logic [WIDTH-1:0] sat_dn;
  logic [WIDTH-1:0] level_next;
  mood_t            mood_q;
  mood_t            mood_d;

  assign tick = ena && (presc == PW'(TICK_DIV - 1));

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ena) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Saturating arithmetic is done one bit wider so the carry/borrow is visible.
  assign sum    = {1'b0, level} + STEP_W;
  assign sat_up = (sum > MAX_W) ? MAX_W[WIDTH-1:0] : sum[WIDTH-1:0];
  assign sat_dn = ({1'b0, level} < STEP_W) ? '0 : level - STEP_W[WIDTH-1:0];

`ifdef DECAY_EN
  localparam int IW = $clog2(DECAY_TICKS + 1);
  logic [IW-1:0] idle_cnt;
  logic          idle_req;
  logic          decay_due;

  assign idle_req  = !pleasure_inc && !pleasure_dec;
  assign decay_due = idle_req && (idle_cnt == IW'(DECAY_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (tick) begin
      idle_cnt <= (idle_req && !decay_due) ? idle_cnt + IW'(1) : '0;
    end
  end
`endif

  // NOTE: level_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    level_next = level;
    case ({pleasure_inc, pleasure_dec})
      2'b10:   level_next = sat_up;
      2'b01:   level_next = sat_dn;
      default: begin
`ifdef DECAY_EN
        if (decay_due) begin
          if (level > MID)      level_next = level - WIDTH'(1);
          else if (level < MID) level_next = level + WIDTH'(1);
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level   <= MID;
      changed <= 1'b0;
    end else begin
      changed <= tick && (level_next != level);
      if (tick) level <= level_next;
    end
  end

  // Mood FSM: state register, next-state logic, output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mood_q <= MOOD_NEUTRAL;
    else        mood_q <= mood_d;
  end

  always_comb begin
    mood_d = mood_q;
    if (ena) begin
      case (mood_q)
        MOOD_NEUTRAL: begin
          if (level >= HI_ON_L)      mood_d = MOOD_HIGH;
          else if (level <= LO_ON_L) mood_d = MOOD_LOW;
        end
        MOOD_HIGH: begin
          if (level <= LO_ON_L)       mood_d = MOOD_LOW;
          else if (level < HI_OFF_L)  mood_d = MOOD_NEUTRAL;
        end
        MOOD_LOW: begin
          if (level >= HI_ON_L)       mood_d = MOOD_HIGH;
          else if (level > LO_OFF_L)  mood_d = MOOD_NEUTRAL;
        end
        default: mood_d = MOOD_NEUTRAL;
      endcase
    end
  end

  always_comb begin
    mood = mood_q;
  end

endmodule

// File: tb/tb_pleasure_integrator.sv
// Scoreboard bench for pleasure_integrator: a cycle-level reference model pushes expected outputs,
// a negedge monitor pops and compares them; directed test-plan sequences plus randomized traffic.
module tb_pleasure_integrator;

  localparam int WIDTH       = 8;
  localparam int STEP        = 4;
  localparam int TICK_DIV    = 4;
  localparam int HI_ON       = 192;
  localparam int HI_OFF      = 160;
  localparam int LO_ON       = 64;
  localparam int LO_OFF      = 96;
  localparam int DECAY_TICKS = 8;
  localparam int MID         = 1 << (WIDTH - 1);
  localparam int MAXV        = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             inc = 1'b0;
  logic             dec = 1'b0;
  logic [WIDTH-1:0] level;
  logic [1:0]       mood;
  logic             changed;

  pleasure_integrator #(
    .WIDTH(WIDTH), .STEP(STEP), .TICK_DIV(TICK_DIV),
    .HI_ON(HI_ON), .HI_OFF(HI_OFF), .LO_ON(LO_ON), .LO_OFF(LO_OFF),
    .DECAY_TICKS(DECAY_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .pleasure_inc(inc), .pleasure_dec(dec),
    .level(level), .mood(mood), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int level;
    int mood;
    int changed;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle phase count, integer level, mood as hysteresis rules.
  int m_level = MID;
  int m_mood  = 1;
  int m_phase = 0;
  int m_idle  = 0;

  function automatic int mood_rule(input int cur, input int lv);
    int r;
    r = cur;
    case (cur)
      1: if (lv >= HI_ON) r = 2; else if (lv <= LO_ON) r = 0;
      2: if (lv <= LO_ON) r = 0; else if (lv < HI_OFF) r = 1;
      0: if (lv >= HI_ON) r = 2; else if (lv > LO_OFF) r = 1;
      default: r = 1;
    endcase
    return r;
  endfunction

  always @(negedge rst_n) begin
    m_level = MID; m_mood = 1; m_phase = 0; m_idle = 0;
    q.delete();
  end

  always @(posedge clk) begin
    int old;
    int chg;
    if (!rst_n) begin
      m_level = MID; m_mood = 1; m_phase = 0; m_idle = 0;
      q.push_back('{MID, 1, 0});
    end else if (!ena) begin
      q.push_back('{m_level, m_mood, 0});
    end else begin
      old = m_level;
      if (m_phase == TICK_DIV - 1) begin
        if (inc && !dec)      m_level = (m_level + STEP > MAXV) ? MAXV : m_level + STEP;
        else if (!inc && dec) m_level = (m_level - STEP < 0) ? 0 : m_level - STEP;
`ifdef DECAY_EN
        if (!inc && !dec) begin
          m_idle++;
          if (m_idle >= DECAY_TICKS) begin
            if (m_level > MID) m_level--;
            else if (m_level < MID) m_level++;
            m_idle = 0;
          end
        end else begin
          m_idle = 0;
        end
`endif
      end
      m_phase = (m_phase + 1) % TICK_DIV;
      m_mood  = mood_rule(m_mood, old);
      chg     = (m_level != old) ? 1 : 0;
      q.push_back('{m_level, m_mood, chg});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("level",   32'(level),   32'(e.level));
      check("mood",    32'(mood),    32'(e.mood));
      check("changed", 32'(changed), 32'(e.changed));
    end
  end

  task automatic run(input logic e, input logic i, input logic d, input int n);
    repeat (n) begin
      @(negedge clk);
      ena = e; inc = i; dec = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; inc = 1'b0; dec = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_level",   32'(level),   32'(MID));
    check("reset_mood",    32'(mood),    32'd1);
    check("reset_changed", 32'(changed), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int mode;
    do_reset();
    run(1, 0, 0, 40);                 // idle: level holds at MID
    check("idle_hold", 32'(level), 32'(MID));
    run(1, 1, 0, 64);                 // 16 ticks -> 192
    run(1, 1, 0, 80);                 // saturate at 255
    run(1, 0, 0, 1);
    check("saturated", 32'(level), 32'(MAXV));
    run(1, 0, 1, 36);                 // 255 -> 219
    run(1, 0, 1, 100);                // down past HI_OFF
    run(1, 0, 1, 120);                // down to LOW range
    run(1, 1, 0, 40);                 // up toward LO_OFF
    run(1, 1, 0, 8);
    run(1, 1, 1, 40);                 // conflict: no change
    run(0, 1, 0, 40);                 // frozen by ena
    run(1, 1, 0, 6);                  // resumes on same phase
    run(1, 0, 1, 400);                // floor at 0
    run(1, 0, 0, 4);
    check("floor", 32'(level), 32'd0);

    for (int blk = 0; blk < 40; blk++) begin
      mode = $urandom_range(0, 3);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        ena = ($urandom_range(0, 9) != 0);
        case (mode)
          0: begin inc = ($urandom_range(0, 3) != 0); dec = ($urandom_range(0, 7) == 0); end
          1: begin inc = ($urandom_range(0, 7) == 0); dec = ($urandom_range(0, 3) != 0); end
          2: begin inc = 1'($urandom); dec = 1'($urandom); end
          default: begin inc = 1'b0; dec = 1'b0; end
        endcase
      end
    end

    // Async reset mid-ramp at level 200.
    do_reset();
    run(1, 1, 0, 72);
    @(posedge clk);
    #1;
    check("ramp_level", 32'(level), 32'd200);
    #1 rst_n = 1'b0;
    #1;
    check("async_level",   32'(level),   32'(MID));
    check("async_mood",    32'(mood),    32'd1);
    check("async_changed", 32'(changed), 32'd0);
    run(0, 0, 0, 2);
    @(negedge clk);
    rst_n = 1'b1;
    run(1, 0, 1, 20);
    run(1, 0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
